// File: rtl/vproc_mem_responder.sv
// ---------------------------------------------------------------------------
// vproc_mem_responder
//
// Memory-side responder for the vproc_top data port. Every request is
// accepted in the cycle it is presented. The access (SRAM or peripheral
// register) is performed in that accept cycle. The response (rvalid/err/rdata)
// comes out exactly RESP_LAT cycles later, in request order.
//
// Address map
//   0x0000_0000 .. MEM_WORDS*4-1     word SRAM with byte-enable writes
//   PERIPH_BASE + 0x00  GPIO_OUT   RW
//   PERIPH_BASE + 0x04  GPIO_OE    RW
//   PERIPH_BASE + 0x08  GPIO_IN    RO
//   PERIPH_BASE + 0x10  TIMER_SET  RW (a write also pulses set_timer)
//   PERIPH_BASE + 0x14  TIMER_STAT RO (bit0 = timer_is_high)
//   Any other address, a write to an RO register, or a peripheral write
//   with partial byte enables returns err=1 and rdata=0, with no side effect.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   mem_req_i/addr/we/be/wdata   request side (always accepted)
//   mem_rvalid_o/err_o/rdata_o   response side, RESP_LAT cycles after accept
//   gpio_out_o, gpio_oe_o        GPIO output values / output enables
//   gpio_in_i                    GPIO pad inputs (already synchronised)
//   timer_set_val, set_timer     digitalTimer load value and one-cycle strobe
//   timer_is_high                digitalTimer status
// ---------------------------------------------------------------------------
module vproc_mem_responder #(
    parameter int          MEM_W       = 32,
    parameter int          MEM_WORDS   = 1024,
    parameter int          RESP_LAT    = 2,
    parameter int          GPIO_W      = 10,
    parameter logic [31:0] PERIPH_BASE = 32'h8000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_req_i,
    input  logic [31:0]        mem_addr_i,
    input  logic               mem_we_i,
    input  logic [MEM_W/8-1:0] mem_be_i,
    input  logic [MEM_W-1:0]   mem_wdata_i,
    output logic               mem_rvalid_o,
    output logic               mem_err_o,
    output logic [MEM_W-1:0]   mem_rdata_o,
    output logic [GPIO_W-1:0]  gpio_out_o,
    output logic [GPIO_W-1:0]  gpio_oe_o,
    input  logic [GPIO_W-1:0]  gpio_in_i,
    output logic [31:0]        timer_set_val,
    output logic               set_timer,
    input  logic               timer_is_high
);

    localparam int          BE_W       = MEM_W / 8;
    localparam int          IDX_W      = $clog2(MEM_WORDS);
    localparam logic [31:0] SRAM_BYTES = 32'(MEM_WORDS) << 2;

    // Peripheral register word offsets (byte offset >> 2)
    localparam logic [5:0] OFF_GPIO_OUT   = 6'h00;
    localparam logic [5:0] OFF_GPIO_OE    = 6'h01;
    localparam logic [5:0] OFF_GPIO_IN    = 6'h02;
    localparam logic [5:0] OFF_TIMER_SET  = 6'h04;
    localparam logic [5:0] OFF_TIMER_STAT = 6'h05;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [MEM_W-1:0]  mem_q [MEM_WORDS];
    logic [MEM_W-1:0]  sram_rd_q;

    logic [GPIO_W-1:0] gpio_out_q;
    logic [GPIO_W-1:0] gpio_oe_q;
    logic [31:0]       timer_val_q;
    logic              set_timer_q;

    logic [RESP_LAT-1:0] valid_q;
    logic [RESP_LAT-1:0] err_q;
    logic [MEM_W-1:0]    rdata_q    [RESP_LAT];
    logic                use_sram_q;
    logic [MEM_W-1:0]    resp_rdata [RESP_LAT];

    // -----------------------------------------------------------------------
    // Request decode
    // -----------------------------------------------------------------------
    logic             accept;
    logic             sram_hit;
    logic             periph_hit;
    logic [5:0]       word_off;
    logic [IDX_W-1:0] sram_idx;
    logic             be_full;
    logic             acc_ok;
    logic             acc_sram_rd;
    logic             acc_sram_wr;
    logic             wr_gpio_out;
    logic             wr_gpio_oe;
    logic             wr_timer;
    logic [MEM_W-1:0] periph_rdata;

    // Requests presented while rst is high are not accepted at all.
    assign accept     = mem_req_i && !rst;
    assign sram_hit   = mem_addr_i < SRAM_BYTES;
    assign periph_hit = mem_addr_i[31:8] == PERIPH_BASE[31:8];
    assign word_off   = mem_addr_i[7:2];
    assign sram_idx   = mem_addr_i[IDX_W+1:2];
    assign be_full    = &mem_be_i;

    always_comb begin
        acc_ok       = 1'b0;
        acc_sram_rd  = 1'b0;
        acc_sram_wr  = 1'b0;
        wr_gpio_out  = 1'b0;
        wr_gpio_oe   = 1'b0;
        wr_timer     = 1'b0;
        periph_rdata = '0;
        if (sram_hit) begin
            acc_ok      = 1'b1;
            acc_sram_rd = !mem_we_i;
            acc_sram_wr = mem_we_i;
        end else if (periph_hit) begin
            case (word_off)
                OFF_GPIO_OUT: begin
                    if (mem_we_i) begin
                        acc_ok      = be_full;
                        wr_gpio_out = be_full;
                    end else begin
                        acc_ok       = 1'b1;
                        periph_rdata = MEM_W'(gpio_out_q);
                    end
                end
                OFF_GPIO_OE: begin
                    if (mem_we_i) begin
                        acc_ok     = be_full;
                        wr_gpio_oe = be_full;
                    end else begin
                        acc_ok       = 1'b1;
                        periph_rdata = MEM_W'(gpio_oe_q);
                    end
                end
                OFF_GPIO_IN: begin
                    if (!mem_we_i) begin
                        acc_ok       = 1'b1;
                        periph_rdata = MEM_W'(gpio_in_i);
                    end
                end
                OFF_TIMER_SET: begin
                    if (mem_we_i) begin
                        acc_ok   = be_full;
                        wr_timer = be_full;
                    end else begin
                        acc_ok       = 1'b1;
                        periph_rdata = MEM_W'(timer_val_q);
                    end
                end
                OFF_TIMER_STAT: begin
                    if (!mem_we_i) begin
                        acc_ok       = 1'b1;
                        periph_rdata = MEM_W'(timer_is_high);
                    end
                end
                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // SRAM: byte-enable write, registered read, no reset on the array so it
    // maps onto block RAM. Only reads load sram_rd_q.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept && acc_sram_wr) begin
            for (int b = 0; b < BE_W; b++) begin
                if (mem_be_i[b]) begin
                    mem_q[sram_idx][b*8 +: 8] <= mem_wdata_i[b*8 +: 8];
                end
            end
        end
        if (accept && acc_sram_rd) begin
            sram_rd_q <= mem_q[sram_idx];
        end
    end

    // -----------------------------------------------------------------------
    // Peripheral registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_out_q  <= '0;
            gpio_oe_q   <= '0;
            timer_val_q <= '0;
            set_timer_q <= 1'b0;
        end else begin
            // Strobe follows each accepted TIMER_SET write, so back-to-back
            // writes give a multi-cycle high.
            set_timer_q <= accept && wr_timer;
            if (accept && wr_gpio_out) gpio_out_q  <= mem_wdata_i[GPIO_W-1:0];
            if (accept && wr_gpio_oe)  gpio_oe_q   <= mem_wdata_i[GPIO_W-1:0];
            if (accept && wr_timer)    timer_val_q <= mem_wdata_i[31:0];
        end
    end

    // -----------------------------------------------------------------------
    // Response pipeline. Stage 0 holds the peripheral read value plus a flag
    // selecting the SRAM output register instead, so the RAM read port stays
    // a plain registered read. The merged value enters stage 1 onwards.
    // -----------------------------------------------------------------------
    logic             valid_d;
    logic             err_d;
    logic             use_sram_d;
    logic [MEM_W-1:0] rdata_d;

    assign valid_d    = accept;
    assign err_d      = accept && !acc_ok;
    assign use_sram_d = accept && acc_sram_rd;
    assign rdata_d    = (accept && acc_ok && !mem_we_i) ? periph_rdata : '0;

    assign resp_rdata[0] = use_sram_q ? sram_rd_q : rdata_q[0];

    for (genvar gi = 1; gi < RESP_LAT; gi++) begin : g_stage
        assign resp_rdata[gi] = rdata_q[gi];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            err_q      <= '0;
            use_sram_q <= 1'b0;
            for (int k = 0; k < RESP_LAT; k++) begin
                rdata_q[k] <= '0;
            end
        end else begin
            valid_q[0] <= valid_d;
            err_q[0]   <= err_d;
            rdata_q[0] <= rdata_d;
            use_sram_q <= use_sram_d;
            for (int k = 1; k < RESP_LAT; k++) begin
                valid_q[k] <= valid_q[k-1];
                err_q[k]   <= err_q[k-1];
                rdata_q[k] <= resp_rdata[k-1];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign mem_rvalid_o  = valid_q[RESP_LAT-1];
    assign mem_err_o     = err_q[RESP_LAT-1];
    assign mem_rdata_o   = resp_rdata[RESP_LAT-1];
    assign gpio_out_o    = gpio_out_q;
    assign gpio_oe_o     = gpio_oe_q;
    assign timer_set_val = timer_val_q;
    assign set_timer     = set_timer_q;

endmodule

// File: tb/tb_vproc_mem_responder.sv
// ---------------------------------------------------------------------------
// Testbench for vproc_mem_responder.
// Directed requests are driven #1 after posedge. On every negedge a reference
// model does two things. First, it compares the DUT outputs with the
// responses it scheduled. Second, it applies the request that the next
// posedge will accept.
// ---------------------------------------------------------------------------
module tb_vproc_mem_responder;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_i;
    logic [31:0] mem_addr_i;
    logic        mem_we_i;
    logic [3:0]  mem_be_i;
    logic [31:0] mem_wdata_i;
    logic        mem_rvalid_o;
    logic        mem_err_o;
    logic [31:0] mem_rdata_o;
    logic [9:0]  gpio_out_o;
    logic [9:0]  gpio_oe_o;
    logic [9:0]  gpio_in_i;
    logic [31:0] timer_set_val;
    logic        set_timer;
    logic        timer_is_high;

    vproc_mem_responder #(
        .MEM_W(32), .MEM_WORDS(1024), .RESP_LAT(L), .GPIO_W(10),
        .PERIPH_BASE(32'h8000_0000)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_req_i(mem_req_i), .mem_addr_i(mem_addr_i), .mem_we_i(mem_we_i),
        .mem_be_i(mem_be_i), .mem_wdata_i(mem_wdata_i),
        .mem_rvalid_o(mem_rvalid_o), .mem_err_o(mem_err_o), .mem_rdata_o(mem_rdata_o),
        .gpio_out_o(gpio_out_o), .gpio_oe_o(gpio_oe_o), .gpio_in_i(gpio_in_i),
        .timer_set_val(timer_set_val), .set_timer(set_timer), .timer_is_high(timer_is_high)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_mem [int unsigned];
    logic [9:0]  m_gpio_out = '0;
    logic [9:0]  m_gpio_oe  = '0;
    logic [31:0] m_tval     = '0;
    logic        m_set      = 1'b0;
    bit          started    = 1'b0;
    // expected responses, indexed by the posedge count after which they show
    logic        ev [16];
    logic        ee [16];
    logic [31:0] ed [16];

    int          resp_cnt = 0;
    int          err_cnt  = 0;
    logic [31:0] last_rdata = '0;

    always @(negedge clk) begin
        bit          ok;
        logic [31:0] rd, a, w;
        int          s, due;
        s = cyc & 15;
        if (started) begin
            check("rvalid", 32'(mem_rvalid_o), 32'(ev[s]));
            if (ev[s]) begin
                check("err", 32'(mem_err_o), 32'(ee[s]));
                check("rdata", mem_rdata_o, ed[s]);
            end
            check("gpio_out", 32'(gpio_out_o), 32'(m_gpio_out));
            check("gpio_oe", 32'(gpio_oe_o), 32'(m_gpio_oe));
            check("timer_set_val", timer_set_val, m_tval);
            check("set_timer", 32'(set_timer), 32'(m_set));
        end
        if (mem_rvalid_o === 1'b1) begin
            resp_cnt++;
            if (mem_err_o) err_cnt++;
            last_rdata = mem_rdata_o;
            $display("resp cycle=%0d err=%0b rdata=%h", cyc, mem_err_o, mem_rdata_o);
        end
        ev[s] = 1'b0;

        // apply the request the next posedge accepts
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                ev[i] = 1'b0; ee[i] = 1'b0; ed[i] = '0;
            end
            m_gpio_out = '0; m_gpio_oe = '0; m_tval = '0; m_set = 1'b0;
            started = 1'b1;
        end else begin
            m_set = 1'b0;
            if (mem_req_i) begin
                ok = 1'b0;
                rd = '0;
                a  = mem_addr_i;
                if (a < 32'd4096) begin
                    ok = 1'b1;
                    w  = m_mem.exists(a >> 2) ? m_mem[a >> 2] : 32'h0;
                    if (mem_we_i) begin
                        for (int b = 0; b < 4; b++)
                            if (mem_be_i[b]) w[b*8 +: 8] = mem_wdata_i[b*8 +: 8];
                        m_mem[a >> 2] = w;
                    end else begin
                        rd = w;
                    end
                end else if (a >= 32'h8000_0000 && a <= 32'h8000_00FF) begin
                    case ((a - 32'h8000_0000) & 32'hFC)
                        32'h00: if (mem_we_i) begin
                                    if (mem_be_i == 4'hF) begin ok = 1; m_gpio_out = mem_wdata_i[9:0]; end
                                end else begin ok = 1; rd = {22'd0, m_gpio_out}; end
                        32'h04: if (mem_we_i) begin
                                    if (mem_be_i == 4'hF) begin ok = 1; m_gpio_oe = mem_wdata_i[9:0]; end
                                end else begin ok = 1; rd = {22'd0, m_gpio_oe}; end
                        32'h08: if (!mem_we_i) begin ok = 1; rd = {22'd0, gpio_in_i}; end
                        32'h10: if (mem_we_i) begin
                                    if (mem_be_i == 4'hF) begin ok = 1; m_tval = mem_wdata_i; m_set = 1; end
                                end else begin ok = 1; rd = m_tval; end
                        32'h14: if (!mem_we_i) begin ok = 1; rd = {31'd0, timer_is_high}; end
                        default: ;
                    endcase
                end
                due = (cyc + L) & 15;
                ev[due] = 1'b1;
                ee[due] = !ok;
                ed[due] = (ok && !mem_we_i) ? rd : 32'h0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic req(input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        @(posedge clk); #1;
        mem_req_i = 1'b1; mem_we_i = w; mem_addr_i = a; mem_be_i = b; mem_wdata_i = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            mem_req_i = 1'b0; mem_we_i = 1'b0;
        end
    endtask

    logic [31:0] t6_addr [8];
    int base_cnt;

    initial begin
        t6_addr = '{32'h10, 32'h20, 32'h8000_0000, 32'h8000_0004,
                    32'hFFC, 32'h10, 32'h8000_0010, 32'h20};
        for (int i = 0; i < 16; i++) begin ev[i] = 0; ee[i] = 0; ed[i] = 0; end
        rst = 1'b1; mem_req_i = 0; mem_addr_i = 0; mem_we_i = 0; mem_be_i = 0;
        mem_wdata_i = 0; gpio_in_i = 0; timer_is_high = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_rvalid", 32'(mem_rvalid_o), 32'd0);
        check("rst_err", 32'(mem_err_o), 32'd0);
        check("rst_rdata", mem_rdata_o, 32'd0);
        check("rst_gpio_out", 32'(gpio_out_o), 32'd0);
        check("rst_gpio_oe", 32'(gpio_oe_o), 32'd0);
        check("rst_timer_val", timer_set_val, 32'd0);
        check("rst_set_timer", 32'(set_timer), 32'd0);

        // 1: write then read next cycle
        req(1, 32'h10, 4'hF, 32'hDEADBEEF);
        req(0, 32'h10, 4'hF, 32'h0);
        idle(4);
        check("t1_rdata", last_rdata, 32'hDEADBEEF);

        // 2: partial byte write merge
        req(1, 32'h20, 4'hF, 32'h1122_3344);
        req(1, 32'h20, 4'b1000, 32'hAA00_0000);
        req(0, 32'h20, 4'hF, 32'h0);
        idle(4);
        check("t2_model", m_mem[32'h8], 32'hAA22_3344);
        check("t2_rdata", last_rdata, 32'hAA22_3344);

        // SRAM boundary: last word, be=0 write is a no-op
        req(1, 32'hFFC, 4'hF, 32'hCAFE_F00D);
        req(1, 32'hFFC, 4'h0, 32'h1234_5678);
        req(0, 32'hFFC, 4'hF, 32'h0);
        idle(4);
        check("last_word", last_rdata, 32'hCAFE_F00D);

        // 3: GPIO
        gpio_in_i = 10'h2A5;
        req(1, 32'h8000_0004, 4'hF, 32'h3FF);
        req(1, 32'h8000_0000, 4'hF, 32'h155);
        req(0, 32'h8000_0008, 4'hF, 32'h0);
        idle(4);
        check("t3_oe", 32'(gpio_oe_o), 32'h3FF);
        check("t3_out", 32'(gpio_out_o), 32'h155);
        check("t3_in", last_rdata, 32'h2A5);

        // 4: timer set strobe and status
        timer_is_high = 1'b1;
        req(1, 32'h8000_0010, 4'hF, 32'd1000);
        idle(1);
        check("t4_strobe_hi", 32'(set_timer), 32'd1);
        check("t4_val", timer_set_val, 32'd1000);
        idle(1);
        check("t4_strobe_lo", 32'(set_timer), 32'd0);
        req(0, 32'h8000_0014, 4'hF, 32'h0);
        idle(4);
        check("t4_stat", last_rdata, 32'd1);
        req(0, 32'h8000_0010, 4'hF, 32'h0);
        idle(4);
        check("t4_readback", last_rdata, 32'd1000);
        req(1, 32'h8000_0010, 4'hF, 32'd5);
        req(1, 32'h8000_0010, 4'hF, 32'd7);
        idle(4);
        check("t4_val2", timer_set_val, 32'd7);

        // 5: error cases
        base_cnt = err_cnt;
        req(0, 32'h4000_0000, 4'hF, 32'h0);
        req(1, 32'h8000_0008, 4'hF, 32'h1);
        req(1, 32'h8000_0000, 4'b0011, 32'h3);
        req(0, 32'h0000_1000, 4'hF, 32'h0);
        req(1, 32'h8000_0014, 4'hF, 32'h1);
        req(0, 32'h8000_000C, 4'hF, 32'h0);
        idle(4);
        check("t5_errs", 32'(err_cnt - base_cnt), 32'd6);
        check("t5_gpio", 32'(gpio_out_o), 32'h155);

        // 6: reset with responses in flight
        base_cnt = resp_cnt;
        for (int i = 0; i < 5; i++) req(0, t6_addr[i], 4'hF, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1; mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h10;
        @(posedge clk); #1;
        rst = 1'b0; mem_req_i = 1'b0;
        for (int i = 5; i < 8; i++) req(0, t6_addr[i], 4'hF, 32'h0);
        idle(5);
        check("t6_resp_cnt", 32'(resp_cnt - base_cnt), 32'd7);
        check("t6_gpio_rst", 32'(gpio_out_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
